// File: rtl/axi_multiport_memory.sv
// Shared 64-bit word memory behind CPU_NB single-beat AXI-lite subordinate ports, one round-robin grant per cycle.
// Optional out-of-range address check (SLVERR) is enabled by defining AXI_ADDR_CHECK_EN.
module axi_multiport_memory #(
  parameter int CPU_NB    = 4,
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [35:0] i_axi_s_aw      [CPU_NB],
  output logic        o_axi_s_awready [CPU_NB],
  input  logic        i_axi_s_awvalid [CPU_NB],
  input  logic [71:0] i_axi_s_w       [CPU_NB],
  output logic        o_axi_s_wready  [CPU_NB],
  input  logic        i_axi_s_wvalid  [CPU_NB],
  output logic [5:0]  o_axi_s_b       [CPU_NB],
  input  logic        i_axi_s_bready  [CPU_NB],
  output logic        o_axi_s_bvalid  [CPU_NB],
  input  logic [35:0] i_axi_s_ar      [CPU_NB],
  output logic        o_axi_s_arready [CPU_NB],
  input  logic        i_axi_s_arvalid [CPU_NB],
  output logic [69:0] o_axi_s_r       [CPU_NB],
  input  logic        i_axi_s_rready  [CPU_NB],
  output logic        o_axi_s_rvalid  [CPU_NB]
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = (CPU_NB > 1) ? $clog2(CPU_NB) : 1;

  logic [CPU_NB-1:0] aw_vld_p0, w_vld_p0, ar_vld_p0, last_wr;
  logic [35:0]       aw_p0 [CPU_NB];
  logic [71:0]       w_p0  [CPU_NB];
  logic [35:0]       ar_p0 [CPU_NB];
  logic [CPU_NB-1:0] b_vld_p1, r_vld_p1;
  logic [5:0]        b_p1  [CPU_NB];
  logic [69:0]       r_p1  [CPU_NB];
  logic [PW-1:0]     rr_ptr, rr_next;

  logic [CPU_NB-1:0] aw_hs, w_hs, ar_hs;
  logic [CPU_NB-1:0] wr_req, rd_req, want_wr, oh_hi, oh_lo, gnt_oh;
  logic              found_hi, found_lo, past_ptr, gnt_vld, gnt_wr;
  logic [35:0]       sel_aw, sel_ar;
  logic [71:0]       sel_w;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic              wr_oor, rd_oor;
  logic [63:0]       rd_word;
  logic [63:0]       mem [MEM_WORDS];

  always_comb begin
    aw_hs = '0;
    w_hs  = '0;
    ar_hs = '0;
    for (int i = 0; i < CPU_NB; i++) begin
      o_axi_s_awready[i] = !rst && !aw_vld_p0[i] && !b_vld_p1[i];
      o_axi_s_wready[i]  = !rst && !w_vld_p0[i] && !b_vld_p1[i];
      o_axi_s_arready[i] = !rst && !ar_vld_p0[i] && !r_vld_p1[i];
      o_axi_s_bvalid[i]  = !rst && b_vld_p1[i];
      o_axi_s_rvalid[i]  = !rst && r_vld_p1[i];
      o_axi_s_b[i]       = o_axi_s_bvalid[i] ? b_p1[i] : '0;
      o_axi_s_r[i]       = o_axi_s_rvalid[i] ? r_p1[i] : '0;
      aw_hs[i] = i_axi_s_awvalid[i] && o_axi_s_awready[i];
      w_hs[i]  = i_axi_s_wvalid[i] && o_axi_s_wready[i];
      ar_hs[i] = i_axi_s_arvalid[i] && o_axi_s_arready[i];
    end
  end

  // Arbiter: first requester at or after rr_ptr, else first requester from port 0
  always_comb begin
    wr_req   = aw_vld_p0 & w_vld_p0;
    rd_req   = ar_vld_p0;
    want_wr  = wr_req & (~rd_req | ~last_wr);
    oh_hi    = '0;
    oh_lo    = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    past_ptr = 1'b0;
    for (int i = 0; i < CPU_NB; i++) begin
      if (PW'(i) == rr_ptr) past_ptr = 1'b1;
      if (!found_hi && past_ptr && (wr_req[i] || rd_req[i])) begin
        found_hi = 1'b1;
        oh_hi[i] = 1'b1;
      end
      if (!found_lo && (wr_req[i] || rd_req[i])) begin
        found_lo = 1'b1;
        oh_lo[i] = 1'b1;
      end
    end
    gnt_oh  = rst ? '0 : (found_hi ? oh_hi : oh_lo);
    gnt_vld = |gnt_oh;
    gnt_wr  = 1'b0;
    sel_aw  = '0;
    sel_w   = '0;
    sel_ar  = '0;
    rr_next = rr_ptr;
    for (int i = 0; i < CPU_NB; i++) begin
      if (gnt_oh[i]) begin
        gnt_wr  = want_wr[i];
        sel_aw  = aw_p0[i];
        sel_w   = w_p0[i];
        sel_ar  = ar_p0[i];
        rr_next = (i == CPU_NB - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_comb begin
    wr_idx = sel_aw[3 +: AW];
    rd_idx = sel_ar[3 +: AW];
`ifdef AXI_ADDR_CHECK_EN
    wr_oor = {32'd0, sel_aw[31:0]} >= 64'(MEM_WORDS) * 64'd8;
    rd_oor = {32'd0, sel_ar[31:0]} >= 64'(MEM_WORDS) * 64'd8;
`else
    wr_oor = 1'b0;
    rd_oor = 1'b0;
`endif
    rd_word = rd_oor ? '0 : mem[rd_idx];
  end

  // Byte offset and (unchecked) upper address bits carry no meaning here
  logic unused_addr_bits;
  assign unused_addr_bits = ^{sel_aw[2:0], sel_ar[2:0], sel_aw[31:3+AW], sel_ar[31:3+AW]};

  always_ff @(posedge clk) begin
    if (gnt_vld && gnt_wr && !wr_oor) begin
      for (int b = 0; b < 8; b++) begin
        if (sel_w[b]) mem[wr_idx][8*b +: 8] <= sel_w[8 + 8*b +: 8];
      end
    end
  end

  // Stage p0: request slots / stage p1: held responses (control state)
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_vld_p0 <= '0;
      w_vld_p0  <= '0;
      ar_vld_p0 <= '0;
      b_vld_p1  <= '0;
      r_vld_p1  <= '0;
      last_wr   <= '0;
      rr_ptr    <= '0;
    end else begin
      if (gnt_vld) rr_ptr <= rr_next;
      for (int i = 0; i < CPU_NB; i++) begin
        if (aw_hs[i]) aw_vld_p0[i] <= 1'b1;
        else if (gnt_oh[i] && gnt_wr) aw_vld_p0[i] <= 1'b0;
        if (w_hs[i]) w_vld_p0[i] <= 1'b1;
        else if (gnt_oh[i] && gnt_wr) w_vld_p0[i] <= 1'b0;
        if (ar_hs[i]) ar_vld_p0[i] <= 1'b1;
        else if (gnt_oh[i] && !gnt_wr) ar_vld_p0[i] <= 1'b0;
        if (gnt_oh[i]) last_wr[i] <= gnt_wr;
        if (gnt_oh[i] && gnt_wr) b_vld_p1[i] <= 1'b1;
        else if (i_axi_s_bready[i]) b_vld_p1[i] <= 1'b0;
        if (gnt_oh[i] && !gnt_wr) r_vld_p1[i] <= 1'b1;
        else if (i_axi_s_rready[i]) r_vld_p1[i] <= 1'b0;
      end
    end
  end

  // Payload registers are not reset; outputs are masked by valid instead
  always_ff @(posedge clk) begin
    for (int i = 0; i < CPU_NB; i++) begin
      if (aw_hs[i]) aw_p0[i] <= i_axi_s_aw[i];
      if (w_hs[i])  w_p0[i]  <= i_axi_s_w[i];
      if (ar_hs[i]) ar_p0[i] <= i_axi_s_ar[i];
      if (gnt_oh[i] && gnt_wr)
        b_p1[i] <= {sel_aw[35:32], (wr_oor ? 2'b10 : 2'b00)};
      if (gnt_oh[i] && !gnt_wr)
        r_p1[i] <= {sel_ar[35:32], rd_word, (rd_oor ? 2'b10 : 2'b00)};
    end
  end
endmodule

// File: tb/tb_axi_multiport_memory.sv
// Directed bench for axi_multiport_memory (CPU_NB=4, MEM_WORDS=1024); honours AXI_ADDR_CHECK_EN if defined.
module tb_axi_multiport_memory;
  logic        clk = 1'b0;
  logic        rst;
  logic [35:0] aw [4];
  logic        awready [4];
  logic        awvalid [4];
  logic [71:0] w [4];
  logic        wready [4];
  logic        wvalid [4];
  logic [5:0]  b [4];
  logic        bready [4];
  logic        bvalid [4];
  logic [35:0] ar [4];
  logic        arready [4];
  logic        arvalid [4];
  logic [69:0] r [4];
  logic        rready [4];
  logic        rvalid [4];

  int total = 0;
  int bad   = 0;

  logic [3:0] awr_v, wr_v, arr_v, bv_v, rv_v;
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      awr_v[i] = awready[i];
      wr_v[i]  = wready[i];
      arr_v[i] = arready[i];
      bv_v[i]  = bvalid[i];
      rv_v[i]  = rvalid[i];
    end
  end

  axi_multiport_memory #(.CPU_NB(4), .MEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .i_axi_s_aw(aw), .o_axi_s_awready(awready), .i_axi_s_awvalid(awvalid),
    .i_axi_s_w(w), .o_axi_s_wready(wready), .i_axi_s_wvalid(wvalid),
    .o_axi_s_b(b), .i_axi_s_bready(bready), .o_axi_s_bvalid(bvalid),
    .i_axi_s_ar(ar), .o_axi_s_arready(arready), .i_axi_s_arvalid(arvalid),
    .o_axi_s_r(r), .i_axi_s_rready(rready), .o_axi_s_rvalid(rvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_req(input int p, input logic [3:0] id, input logic [31:0] addr,
                           input logic [63:0] data, input logic [7:0] strb);
    aw[p] = {id, addr};
    w[p]  = {data, strb};
    awvalid[p] = 1'b1;
    wvalid[p]  = 1'b1;
    tick;
    awvalid[p] = 1'b0;
    wvalid[p]  = 1'b0;
  endtask

  task automatic read_req(input int p, input logic [3:0] id, input logic [31:0] addr);
    ar[p] = {id, addr};
    arvalid[p] = 1'b1;
    tick;
    arvalid[p] = 1'b0;
  endtask

  task automatic b_resp(input string tag, input int p, input logic [5:0] exp_b);
    int n = 1;
    while (!bvalid[p] && n < 20) begin tick; n++; end
    chk({tag, "_lat"}, n, 2);
    chk(tag, b[p], exp_b);
    bready[p] = 1'b1;
    tick;
    bready[p] = 1'b0;
  endtask

  task automatic r_resp(input string tag, input int p, input logic [69:0] exp_r);
    int n = 1;
    while (!rvalid[p] && n < 20) begin tick; n++; end
    chk({tag, "_lat"}, n, 2);
    chk(tag, r[p], exp_r);
    rready[p] = 1'b1;
    tick;
    rready[p] = 1'b0;
  endtask

  localparam logic [63:0] D0 = 64'h1122334455667788;
  localparam logic [63:0] DA = 64'hA5A5_0000_1234_5678;
  localparam logic [63:0] DB = 64'h0BAD_F00D_CAFE_BEEF;
  localparam logic [63:0] DC = 64'hC0C0_C1C1_C2C2_C3C3;
  localparam logic [63:0] DD = 64'hDDDD_0001_DDDD_0002;
  localparam logic [63:0] DE = 64'hEEEE_EEEE_0000_0E0E;
  localparam logic [63:0] DF = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] DG = 64'h6666_7777_8888_9999;
  localparam logic [63:0] DH = 64'h4848_4848_4848_4848;

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      aw[i] = '0; w[i] = '0; ar[i] = '0;
      awvalid[i] = 1'b0; wvalid[i] = 1'b0; arvalid[i] = 1'b0;
      bready[i] = 1'b0; rready[i] = 1'b0;
    end
    tick;
    tick;
    chk("rst_rdy", {arr_v, wr_v, awr_v}, 12'h000);
    chk("rst_vld", {rv_v, bv_v}, 8'h00);
    rst = 1'b0;
    tick;
    chk("idle_rdy", {arr_v, wr_v, awr_v}, 12'hfff);
    chk("idle_vld", {rv_v, bv_v}, 8'h00);
    chk("idle_b0", b[0], 6'h00);

    // Basic write then read on port 0
    write_req(0, 4'd3, 32'h10, D0, 8'hFF);
    chk("wr_hold_rdy", awr_v[0], 1'b0);
    b_resp("b_basic", 0, {4'd3, 2'b00});
    chk("aw_rdy_after_b", awr_v[0], 1'b1);
    read_req(0, 4'd5, 32'h10);
    r_resp("r_basic", 0, {4'd5, D0, 2'b00});

    // Partial strobe on port 1; addr[2:0] ignored on the read
    write_req(1, 4'd1, 32'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    b_resp("b_ones", 1, {4'd1, 2'b00});
    write_req(1, 4'd2, 32'h20, 64'h0, 8'h0F);
    b_resp("b_strb", 1, {4'd2, 2'b00});
    read_req(1, 4'd6, 32'h24);
    r_resp("r_strb", 1, {4'd6, 64'hFFFF_FFFF_0000_0000, 2'b00});

    // Seed words for ports 2 and 3; last grant on port 3 returns pointer to 0
    write_req(2, 4'd4, 32'h30, DA, 8'hFF);
    b_resp("b_p2", 2, {4'd4, 2'b00});
    write_req(3, 4'd5, 32'h38, DB, 8'hFF);
    b_resp("b_p3", 3, {4'd5, 2'b00});

    // Simultaneous reads on all ports: round-robin 0,1,2,3
    ar[0] = {4'd8, 32'h10};
    ar[1] = {4'd9, 32'h20};
    ar[2] = {4'd10, 32'h30};
    ar[3] = {4'd11, 32'h38};
    for (int i = 0; i < 4; i++) arvalid[i] = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) arvalid[i] = 1'b0;
    chk("rr_t1", rv_v, 4'b0000);
    tick; chk("rr_t2", rv_v, 4'b0001);
    tick; chk("rr_t3", rv_v, 4'b0011);
    tick; chk("rr_t4", rv_v, 4'b0111);
    tick; chk("rr_t5", rv_v, 4'b1111);
    chk("rr_r0", r[0], {4'd8, D0, 2'b00});
    chk("rr_r1", r[1], {4'd9, 64'hFFFF_FFFF_0000_0000, 2'b00});
    chk("rr_r2", r[2], {4'd10, DA, 2'b00});
    chk("rr_r3", r[3], {4'd11, DB, 2'b00});
    for (int i = 0; i < 4; i++) rready[i] = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) rready[i] = 1'b0;
    chk("rr_clear", rv_v, 4'b0000);
    chk("rr_payload0", r[2], 70'h0);

    // Write and read pending together on port 0: write first, read sees new data
    aw[0] = {4'd2, 32'h40};
    w[0]  = {DC, 8'hFF};
    ar[0] = {4'd7, 32'h40};
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; arvalid[0] = 1'b1;
    tick;
    awvalid[0] = 1'b0; wvalid[0] = 1'b0; arvalid[0] = 1'b0;
    chk("wr_rd_t1", {rv_v[0], bv_v[0]}, 2'b00);
    tick;
    chk("wr_rd_t2", {rv_v[0], bv_v[0]}, 2'b01);
    tick;
    chk("wr_rd_t3", {rv_v[0], bv_v[0]}, 2'b11);
    chk("wr_rd_r", r[0], {4'd7, DC, 2'b00});
    chk("wr_rd_b", b[0], {4'd2, 2'b00});
    bready[0] = 1'b1; rready[0] = 1'b1;
    tick;
    bready[0] = 1'b0; rready[0] = 1'b0;

    // Back-pressure on B: response holds, AW stays blocked
    write_req(2, 4'd7, 32'h48, DD, 8'hFF);
    tick;
    for (int k = 0; k < 5; k++) begin
      chk("bp_b", {bv_v[2], b[2]}, {1'b1, 4'd7, 2'b00});
      chk("bp_awrdy", awr_v[2], 1'b0);
      tick;
    end
    bready[2] = 1'b1;
    tick;
    bready[2] = 1'b0;
    chk("bp_clear", bv_v[2], 1'b0);
    chk("bp_awrdy_after", awr_v[2], 1'b1);

    // Address beyond the memory
    write_req(3, 4'd1, 32'h0, DE, 8'hFF);
    b_resp("b_w0", 3, {4'd1, 2'b00});
    write_req(3, 4'd2, 32'h2000, DF, 8'hFF);
`ifdef AXI_ADDR_CHECK_EN
    b_resp("b_oor", 3, {4'd2, 2'b10});
    read_req(3, 4'd3, 32'h0);
    r_resp("r_w0_kept", 3, {4'd3, DE, 2'b00});
    read_req(3, 4'd4, 32'h2000);
    r_resp("r_oor", 3, {4'd4, 64'h0, 2'b10});
`else
    b_resp("b_alias", 3, {4'd2, 2'b00});
    read_req(3, 4'd3, 32'h0);
    r_resp("r_w0_alias", 3, {4'd3, DF, 2'b00});
    read_req(3, 4'd4, 32'h2000);
    r_resp("r_alias", 3, {4'd4, DF, 2'b00});
`endif

    // Reset lands on the cycle the port 1 write would be granted
    write_req(1, 4'd3, 32'h50, DG, 8'hFF);
    b_resp("b_pre_rst", 1, {4'd3, 2'b00});
    write_req(1, 4'd4, 32'h50, DH, 8'hFF);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", {arr_v, wr_v, awr_v}, 12'h000);
    chk("mid_rst_vld", {rv_v, bv_v}, 8'h00);
    tick;
    rst = 1'b0;
    tick;
    chk("post_rst_b", bv_v[1], 1'b0);
    chk("post_rst_awrdy", awr_v[1], 1'b1);
    tick;
    chk("post_rst_b2", {bv_v[1], b[1]}, 7'h00);
    read_req(1, 4'd9, 32'h50);
    r_resp("r_post_rst", 1, {4'd9, DG, 2'b00});
    read_req(0, 4'd1, 32'h10);
    r_resp("r_mem_kept", 0, {4'd1, D0, 2'b00});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
